// File: rtl/instr_mem_responder.sv
// Instruction memory with a single-cycle registered fetch port and a byte-stream
// loader that packs big-endian bytes into 32-bit words at sequential addresses.
module instr_mem_responder #(
    parameter int          ADDR_WIDTH  = 11,
    parameter int          DEPTH_WORDS = 512,
    parameter logic [31:0] NOP_WORD    = 32'h00000000
) (
    input  logic                  Clock,
    input  logic                  Reset,
    input  logic [ADDR_WIDTH-1:0] Fetch_Addr,
    input  logic                  Fetch_En,
    output logic [31:0]           Instruction,
    output logic                  Fetch_Valid,
    input  logic                  Load_Start,
    input  logic                  Load_Valid,
    input  logic [7:0]            Load_Byte,
    input  logic                  Load_End,
    output logic                  Load_Busy,
    output logic                  Load_Full,
    output logic [ADDR_WIDTH-2:0] Word_Count
);

    localparam int WA = ADDR_WIDTH - 2;
    localparam int CW = ADDR_WIDTH - 1;
    localparam logic [CW-1:0] LAST_WORD = CW'(DEPTH_WORDS - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD,
        ST_RUN
    } state_t;

    state_t          state_reg;
    logic [1:0]      byte_idx_reg;
    logic [23:0]     asm_reg;
    logic [CW-1:0]   word_count_reg;
    logic            full_reg;
    logic [31:0]     instr_reg;
    logic            fetch_valid_reg;

    logic [31:0]     mem [DEPTH_WORDS];

    logic            byte_accept;
    logic            word_write;
    logic            fetch_accept;
    logic [WA-1:0]   wr_addr;
    logic [WA-1:0]   rd_addr;
    logic [31:0]     wr_word;
    logic            unused_addr_lsbs;

    // Load_Start pre-empts everything in its cycle, including a byte or a fetch.
    assign byte_accept  = (state_reg == ST_LOAD) && !Load_Start && Load_Valid && !full_reg;
    assign word_write   = byte_accept && (byte_idx_reg == 2'd3);
    assign wr_word      = {asm_reg, Load_Byte};
    assign wr_addr      = word_count_reg[WA-1:0];
    assign rd_addr      = Fetch_Addr[ADDR_WIDTH-1:2];
    assign fetch_accept = Fetch_En && (state_reg != ST_LOAD) && !Load_Start;
    assign unused_addr_lsbs = ^Fetch_Addr[1:0];

    // Memory array has no reset so it maps onto block RAM and survives Reset.
    always_ff @(posedge Clock) begin
        if (word_write) begin
            mem[wr_addr] <= wr_word;
        end
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            instr_reg       <= NOP_WORD;
            fetch_valid_reg <= 1'b0;
        end else if (fetch_accept) begin
            instr_reg       <= mem[rd_addr];
            fetch_valid_reg <= 1'b1;
        end else begin
            instr_reg       <= NOP_WORD;
            fetch_valid_reg <= 1'b0;
        end
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_reg      <= ST_IDLE;
            byte_idx_reg   <= 2'd0;
            asm_reg        <= 24'd0;
            word_count_reg <= '0;
            full_reg       <= 1'b0;
        end else if (Load_Start) begin
            state_reg      <= ST_LOAD;
            byte_idx_reg   <= 2'd0;
            asm_reg        <= 24'd0;
            word_count_reg <= '0;
            full_reg       <= 1'b0;
        end else begin
            case (state_reg)
                ST_LOAD: begin
                    if (byte_accept) begin
                        asm_reg      <= {asm_reg[15:0], Load_Byte};
                        byte_idx_reg <= byte_idx_reg + 2'd1;
                    end
                    if (word_write) begin
                        word_count_reg <= word_count_reg + 1'b1;
                        if (word_count_reg == LAST_WORD) begin
                            full_reg <= 1'b1;
                        end
                    end
                    // Leaving LOAD drops any partial word (byte accepted above first).
                    if (Load_End || full_reg) begin
                        state_reg    <= ST_RUN;
                        byte_idx_reg <= 2'd0;
                        asm_reg      <= 24'd0;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign Instruction = instr_reg;
    assign Fetch_Valid = fetch_valid_reg;
    assign Load_Busy   = (state_reg == ST_LOAD);
    assign Load_Full   = full_reg;
    assign Word_Count  = word_count_reg;

endmodule

// File: tb/tb_instr_mem_responder.sv
// Directed bench for instr_mem_responder: loads images, fetches them back and
// checks load-boundary, overflow, refusal and mid-load reset behaviour.
module tb_instr_mem_responder;

    logic        Clock;
    logic        Reset;
    logic [10:0] Fetch_Addr;
    logic        Fetch_En;
    logic [31:0] Instruction;
    logic        Fetch_Valid;
    logic        Load_Start;
    logic        Load_Valid;
    logic [7:0]  Load_Byte;
    logic        Load_End;
    logic        Load_Busy;
    logic        Load_Full;
    logic [9:0]  Word_Count;

    int checks   = 0;
    int failures = 0;

    instr_mem_responder #(
        .ADDR_WIDTH (11),
        .DEPTH_WORDS(512),
        .NOP_WORD   (32'h00000000)
    ) dut (
        .Clock      (Clock),
        .Reset      (Reset),
        .Fetch_Addr (Fetch_Addr),
        .Fetch_En   (Fetch_En),
        .Instruction(Instruction),
        .Fetch_Valid(Fetch_Valid),
        .Load_Start (Load_Start),
        .Load_Valid (Load_Valid),
        .Load_Byte  (Load_Byte),
        .Load_End   (Load_End),
        .Load_Busy  (Load_Busy),
        .Load_Full  (Load_Full),
        .Word_Count (Word_Count)
    );

    initial begin
        Clock = 1'b0;
        forever #5 Clock = ~Clock;
    end

    task automatic tick();
        @(posedge Clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        Load_Valid = 1'b1;
        Load_Byte  = b;
        tick();
        Load_Valid = 1'b0;
    endtask

    task automatic pulse_start();
        Load_Start = 1'b1;
        tick();
        Load_Start = 1'b0;
    endtask

    task automatic pulse_end();
        Load_End = 1'b1;
        tick();
        Load_End = 1'b0;
    endtask

    task automatic fetch_chk(input string tag, input logic [10:0] addr, input logic [31:0] exp);
        Fetch_En   = 1'b1;
        Fetch_Addr = addr;
        tick();
        Fetch_En   = 1'b0;
        chk(tag, Instruction, exp);
        chk({tag, "_valid"}, {31'd0, Fetch_Valid}, 32'd1);
        $display("fetch %s addr=%03h instr=%08h valid=%0b", tag, addr, Instruction, Fetch_Valid);
    endtask

    function automatic logic [7:0] pat(input int i);
        return 8'((i * 7 + 3) & 255);
    endfunction

    logic [7:0] img1 [8];

    initial begin
        img1[0] = 8'h8C; img1[1] = 8'h01; img1[2] = 8'h00; img1[3] = 8'h04;
        img1[4] = 8'h20; img1[5] = 8'h02; img1[6] = 8'h00; img1[7] = 8'h05;

        Reset = 1'b1; Fetch_Addr = '0; Fetch_En = 1'b0; Load_Start = 1'b0;
        Load_Valid = 1'b0; Load_Byte = '0; Load_End = 1'b0;
        tick(); tick();
        Reset = 1'b0;
        chk("rst_instr", Instruction, 32'h0);
        chk("rst_valid", {31'd0, Fetch_Valid}, 32'd0);
        chk("rst_busy",  {31'd0, Load_Busy}, 32'd0);
        chk("rst_full",  {31'd0, Load_Full}, 32'd0);
        chk("rst_count", {22'd0, Word_Count}, 32'd0);
        $display("reset done");

        // Test 1: two-word image
        pulse_start();
        chk("t1_busy", {31'd0, Load_Busy}, 32'd1);
        for (int i = 0; i < 8; i++) send_byte(img1[i]);
        pulse_end();
        chk("t1_count", {22'd0, Word_Count}, 32'd2);
        chk("t1_busy_end", {31'd0, Load_Busy}, 32'd0);
        $display("load t1 words=%0d", Word_Count);
        fetch_chk("t1_w0", 11'h000, 32'h8C010004);
        fetch_chk("t1_w1", 11'h004, 32'h20020005);
        tick();
        chk("idle_valid", {31'd0, Fetch_Valid}, 32'd0);
        chk("idle_instr", Instruction, 32'h0);

        // Test 2: back-to-back fetches, low address bits ignored
        Fetch_En = 1'b1;
        Fetch_Addr = 11'h004; tick(); chk("t2_a", Instruction, 32'h20020005);
        Fetch_Addr = 11'h005; tick(); chk("t2_b", Instruction, 32'h20020005);
        Fetch_Addr = 11'h007; tick(); chk("t2_c", Instruction, 32'h20020005);
        chk("t2_valid", {31'd0, Fetch_Valid}, 32'd1);
        Fetch_Addr = 11'h000; tick(); chk("t2_d", Instruction, 32'h8C010004);
        Fetch_En = 1'b0;
        $display("b2b fetch done");

        // Load_Valid outside LOAD is ignored
        send_byte(8'hAA);
        chk("ignore_count", {22'd0, Word_Count}, 32'd2);

        // Test 3: partial trailing word dropped
        pulse_start();
        for (int i = 0; i < 6; i++) send_byte(8'(8'h11 * (i + 1)));
        pulse_end();
        chk("t3_count", {22'd0, Word_Count}, 32'd1);
        $display("load t3 words=%0d", Word_Count);
        fetch_chk("t3_w0", 11'h000, 32'h11223344);
        fetch_chk("t3_w1", 11'h004, 32'h20020005);

        // Test 4/5: fill the memory with fetch requested throughout the load
        Fetch_En = 1'b1;
        Load_Start = 1'b1;
        tick();
        Load_Start = 1'b0;
        chk("t5_start_valid", {31'd0, Fetch_Valid}, 32'd0);
        for (int i = 0; i < 2048; i++) begin
            send_byte(pat(i));
            if (i < 6) begin
                chk("t5_load_valid", {31'd0, Fetch_Valid}, 32'd0);
                chk("t5_load_instr", Instruction, 32'h0);
            end
        end
        chk("t4_full", {31'd0, Load_Full}, 32'd1);
        chk("t4_count", {22'd0, Word_Count}, 32'd512);
        chk("t4_busy", {31'd0, Load_Busy}, 32'd1);
        send_byte(8'hFF);
        chk("t4_extra_valid", {31'd0, Fetch_Valid}, 32'd0);
        chk("t4_run", {31'd0, Load_Busy}, 32'd0);
        chk("t4_full_sticky", {31'd0, Load_Full}, 32'd1);
        chk("t4_count_hold", {22'd0, Word_Count}, 32'd512);
        Fetch_En = 1'b0;
        $display("load t4 words=%0d full=%0b", Word_Count, Load_Full);
        fetch_chk("t4_w0", 11'h000, 32'h030A1118);
        fetch_chk("t4_w4", 11'h010, 32'h737A8188);
        fetch_chk("t4_w511", 11'h7FC, 32'hE7EEF5FC);

        // Start and End together: start wins
        Load_Start = 1'b1; Load_End = 1'b1;
        tick();
        Load_Start = 1'b0; Load_End = 1'b0;
        chk("se_busy", {31'd0, Load_Busy}, 32'd1);
        chk("se_full", {31'd0, Load_Full}, 32'd0);

        // Test 6: reset mid-load keeps finished words, drops the partial one
        pulse_start();
        for (int i = 0; i < 23; i++) send_byte(8'(8'h40 + i));
        chk("t6_count_pre", {22'd0, Word_Count}, 32'd5);
        Reset = 1'b1;
        tick();
        Reset = 1'b0;
        chk("t6_count", {22'd0, Word_Count}, 32'd0);
        chk("t6_busy", {31'd0, Load_Busy}, 32'd0);
        chk("t6_instr", Instruction, 32'h0);
        $display("mid-load reset done");
        fetch_chk("t6_w0", 11'h000, 32'h40414243);
        fetch_chk("t6_w4", 11'h010, 32'h50515253);
        fetch_chk("t6_w5", 11'h014, 32'h8F969DA4);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/instr_mem_responder.md
Name: instr_mem_responder

Overview:
Instruction memory that answers fetch requests from the program counter. It also accepts a program image as a byte stream from the debug/UART loader. A small FSM (IDLE / LOAD / RUN) arbitrates between loading and fetching. Fetch reads are registered and complete in one cycle. Loading packs four bytes into each 32-bit word and writes words at sequential addresses.

Parameters:
ADDR_WIDTH, 11, byte-address width of the fetch port; the address space is 0x000–0x7FF.
DEPTH_WORDS, 512, number of 32-bit words stored; must equal 2^(ADDR_WIDTH-2).
NOP_WORD, 32'h00000000, value driven on Instruction when no valid fetch data exists.

Ports:
Clock  input  1  system clock; all state updates on the rising edge.
Reset  input  1  synchronous, active-high reset.
Fetch_Addr  input  ADDR_WIDTH  byte address from the PC; bits [1:0] ignored.
Fetch_En  input  1  fetch request, sampled on the rising edge.
Instruction  output  32  registered fetch data.
Fetch_Valid  output  1  high when Instruction holds the data for the previous cycle's accepted request.
Load_Start  input  1  one-cycle pulse: enter LOAD and clear the write pointer.
Load_Valid  input  1  Load_Byte is valid this cycle.
Load_Byte  input  8  program byte; the first byte of each word is the MSB (big-endian).
Load_End  input  1  one-cycle pulse: end loading and go to RUN.
Load_Busy  output  1  high while in LOAD.
Load_Full  output  1  sticky; set when DEPTH_WORDS words have been written.
Word_Count  output  ADDR_WIDTH-1  number of complete words written since the last Load_Start.

Behaviour:
- Reset (synchronous):
  - State goes to IDLE.
  - Instruction = NOP_WORD; Fetch_Valid = 0; Load_Busy = 0; Load_Full = 0; Word_Count = 0.
  - Byte index and assembly register are cleared.
  - Memory contents are NOT cleared.
  - Reset asserted mid-load discards any partial word and leaves already-written words intact.
- FSM states:
  - IDLE: accepts fetches.
  - LOAD: accepts bytes; fetches are refused.
  - RUN: accepts fetches.
- FSM transitions:
  - IDLE or RUN + Load_Start -> LOAD. Word_Count cleared, byte index cleared, Load_Full cleared.
  - LOAD + Load_End -> RUN.
  - LOAD + Load_Full set -> RUN on the next cycle.
  - Load_Start while already in LOAD restarts the load: pointer cleared, partial word discarded.
  - Load_Start and Load_End in the same cycle: Load_Start wins.
- Loading:
  - Each Load_Valid cycle shifts Load_Byte into the assembly register and increments the byte index (0..3).
  - On the 4th byte, the word {b0,b1,b2,b3} is written to mem[Word_Count] in that same edge, Word_Count increments, and the byte index wraps to 0.
  - When Word_Count reaches DEPTH_WORDS, Load_Full sets. Further Load_Valid bytes are ignored; there is no wrap and no overwrite.
  - Load_End with a partial word (byte index ≠ 0): the partial bytes are dropped and not written.
  - Load_Valid outside LOAD is ignored.
  - Load_Valid together with Load_End in the same cycle: the byte is accepted first, then the partial-word rule applies.
- Fetch:
  - Fetch_En is honoured only in IDLE or RUN.
  - On an accepted fetch: Instruction <= mem[Fetch_Addr[ADDR_WIDTH-1:2]] and Fetch_Valid <= 1. Latency is exactly 1 cycle.
  - Back-to-back fetches give one result per cycle.
  - Fetch_En low, or any cycle in LOAD: Fetch_Valid <= 0 and Instruction <= NOP_WORD.
  - A fetch issued in the same cycle as Load_Start is refused.
  - Word addresses at or above Word_Count in RUN are still read (stale contents); gating them is not this block's job.
- Widths: Word_Count must hold 0..DEPTH_WORDS, i.e. ADDR_WIDTH-1 bits.

Test Plan:
1. Reset, Load_Start, bytes 8C,01,00,04,20,02,00,05, Load_End -> Word_Count=2, state RUN, Load_Busy=0. Fetch 0x000 -> next cycle Instruction=8C010004, Fetch_Valid=1. Fetch 0x004 -> 20020005.
2. Fetch addresses 0x004, 0x005, 0x007 back-to-back -> all return the same word on three consecutive cycles, each 1 cycle after its request.
3. Load 6 bytes then Load_End -> Word_Count=1; word 1 unchanged from its prior value.
4. Stream 2049 bytes (512 words plus one extra byte) -> Load_Full=1 after the 2048th byte, state RUN the next cycle, mem[0] not overwritten by the extra byte.
5. Fetch_En high during LOAD -> Fetch_Valid=0, Instruction=00000000 throughout.
6. Reset asserted after 3 bytes of word 5 -> Word_Count=0, Load_Busy=0, Instruction=00000000. Words 0–4 still read back correctly after a fetch in IDLE.
